fft_bf_scheduler: RTL and testbench

- Sequences one shared radix-2 butterfly datapath through a complete in-place decimation-in-time FFT of 2^LOG2N complex points.
- Sample memory is loaded in bit-reversed order before start.
- Per butterfly: generates the operand A/B addresses and the twiddle index, handshakes with the butterfly unit (start/done), then issues a write-back strobe.
- Sits between the top-level control and the butterfly datapath/sample RAM.

---
 rtl/fft_bf_scheduler_if.sv | 28 ++
 rtl/fft_bf_scheduler.sv | 126 ++++++++++++
 tb/tb_fft_bf_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fft_bf_scheduler_if.sv
// Control/handshake bundle between the FFT butterfly scheduler and its surroundings
// (top-level control, butterfly datapath, sample RAM).
interface fft_bf_scheduler_if #(
  parameter int LOG2N = 3
);
  logic             start;
  logic             hold;
  logic             bf_done;
  logic             bf_start;
  logic             wr_en;
  logic [LOG2N-1:0] a_addr;
  logic [LOG2N-1:0] b_addr;
  logic [LOG2N-2:0] tw_idx;
  logic [3:0]       stage;
  logic             busy;
  logic             done;

  // The scheduler drives the butterfly bus.
  modport master (
    input  start, hold, bf_done,
    output bf_start, wr_en, a_addr, b_addr, tw_idx, stage, busy, done
  );

  modport slave (
    output start, hold, bf_done,
    input  bf_start, wr_en, a_addr, b_addr, tw_idx, stage, busy, done
  );
endinterface

// File: rtl/fft_bf_scheduler.sv
// Walks one shared radix-2 butterfly through an in-place DIT FFT of 2^LOG2N points:
// per butterfly it presents A/B addresses and twiddle index, waits for bf_done, then strobes write-back.
module fft_bf_scheduler #(
  parameter int LOG2N = 3
) (
  input  logic               Clock,
  input  logic               nReset,
  fft_bf_scheduler_if.master bus
);
  localparam int KW = LOG2N - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t           state_reg;
  logic [3:0]       stage_reg;
  logic [KW-1:0]    k_reg;
  logic [LOG2N-1:0] a_addr_reg;
  logic [LOG2N-1:0] b_addr_reg;
  logic [KW-1:0]    tw_idx_reg;
  logic             wr_en_reg;
  logic             done_reg;
  logic             busy_reg;

  logic             last_k;
  logic             last_stage;
  logic             load_addr;
  logic [3:0]       stage_next;
  logic [KW-1:0]    k_next;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] a_next;
  logic [LOG2N-1:0] b_next;
  logic [KW-1:0]    tw_next;

  assign last_k     = (k_reg == {KW{1'b1}});
  assign last_stage = (stage_reg == 4'(LOG2N - 1));

  // Addresses are loaded whenever a butterfly is about to be issued: on run start or after a non-final write-back.
  assign load_addr = ((state_reg == IDLE) && bus.start) ||
                     ((state_reg == WRITE) && !(last_k && last_stage));

  always_comb begin
    stage_next = 4'd0;
    k_next     = '0;
    if (state_reg != IDLE) begin
      if (last_k) begin
        stage_next = stage_reg + 4'd1;
        k_next     = '0;
      end else begin
        stage_next = stage_reg;
        k_next     = k_reg + KW'(1);
      end
    end
    span    = LOG2N'(1) << stage_next;
    j       = LOG2N'(k_next) & (span - LOG2N'(1));
    grp     = LOG2N'(k_next) >> stage_next;
    a_next  = (grp << (stage_next + 4'd1)) + j;
    b_next  = a_next + span;
    tw_next = KW'(j << (4'(LOG2N - 1) - stage_next));
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg  <= IDLE;
      stage_reg  <= 4'd0;
      k_reg      <= '0;
      a_addr_reg <= '0;
      b_addr_reg <= '0;
      tw_idx_reg <= '0;
      wr_en_reg  <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;

      if (load_addr) begin
        stage_reg  <= stage_next;
        k_reg      <= k_next;
        a_addr_reg <= a_next;
        b_addr_reg <= b_next;
        tw_idx_reg <= tw_next;
      end

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= ISSUE;
            busy_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          if (!bus.hold) state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.bf_done) begin
            state_reg <= WRITE;
            wr_en_reg <= 1'b1;
          end
        end
        WRITE: begin
          if (last_k && last_stage) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= ISSUE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // bf_start must drop in the very cycle hold is high, so it is decoded from state and hold directly.
  assign bus.bf_start = (state_reg == ISSUE) && !bus.hold;
  assign bus.wr_en    = wr_en_reg;
  assign bus.done     = done_reg;
  assign bus.busy     = busy_reg;
  assign bus.a_addr   = a_addr_reg;
  assign bus.b_addr   = b_addr_reg;
  assign bus.tw_idx   = tw_idx_reg;
  assign bus.stage    = stage_reg;
endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Self-checking bench for fft_bf_scheduler: cycle-by-cycle comparison against a butterfly-list reference model.
module tb_fft_bf_scheduler;
  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int NB    = (N / 2) * LOG2N;

  logic Clock = 1'b0;
  logic nReset;
  always #5 Clock = ~Clock;

  fft_bf_scheduler_if #(.LOG2N(LOG2N)) bus ();
  fft_bf_scheduler #(.LOG2N(LOG2N)) dut (.Clock(Clock), .nReset(nReset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int m_s[NB], m_a[NB], m_b[NB], m_tw[NB];
  int cap_a[NB], cap_b[NB], cap_tw[NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bf_start"}, 32'(bus.bf_start), 0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    0);
    chk({tag, "_done"},     32'(bus.done),     0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
    chk({tag, "_a_addr"},   32'(bus.a_addr),   0);
    chk({tag, "_b_addr"},   32'(bus.b_addr),   0);
    chk({tag, "_tw_idx"},   32'(bus.tw_idx),   0);
    chk({tag, "_stage"},    32'(bus.stage),    0);
  endtask

  // One FFT run. Drives bf_done/hold/start, predicts every output each cycle from the butterfly list.
  task automatic run_fft(input int lat_max, input int hold_idx, input bit poke, input int abort_idx,
                         output int done_cycle, output bit aborted);
    int cyc, idx, wait_left, hold_cnt, nbs, nwr;
    bit issue_pending, waiting, acc, acc_prev, done_pending, finished, hold_now, exp_bs, exp_wr, exp_done;
    done_cycle = -1; aborted = 0;
    idx = 0; wait_left = 0; hold_cnt = 0; nbs = 0; nwr = 0;
    issue_pending = 1; waiting = 0; acc_prev = 0; done_pending = 0; finished = 0;
    @(posedge Clock); #1;
    bus.start = 1'b1; bus.hold = 1'b0; bus.bf_done = 1'b0;
    #1;
    chk("accept_busy", 32'(bus.busy), 0);
    chk("accept_bf_start", 32'(bus.bf_start), 0);
    cyc = 0;
    while (!finished && !aborted && cyc < 1000) begin
      @(posedge Clock); #1; cyc++;
      bus.start = poke && (cyc == 10 || done_pending);
      hold_now  = issue_pending && (idx == hold_idx) && (hold_cnt < 4);
      bus.hold  = hold_now;
      if (hold_now) hold_cnt++;
      acc = 0;
      if (waiting) begin
        if (wait_left == 0) begin bus.bf_done = 1'b1; acc = 1; end
        else begin bus.bf_done = 1'b0; wait_left--; end
      end else begin
        bus.bf_done = (lat_max > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      exp_bs   = issue_pending && !hold_now;
      exp_wr   = acc_prev;
      exp_done = done_pending;
      chk("bf_start", 32'(bus.bf_start), 32'(exp_bs));
      chk("wr_en",    32'(bus.wr_en),    32'(exp_wr));
      chk("done",     32'(bus.done),     32'(exp_done));
      chk("busy",     32'(bus.busy),     32'(!exp_done));
      nbs += int'(bus.bf_start);
      nwr += int'(bus.wr_en);
      if (issue_pending || waiting || exp_wr) begin
        chk("a_addr", 32'(bus.a_addr), m_a[idx]);
        chk("b_addr", 32'(bus.b_addr), m_b[idx]);
        chk("tw_idx", 32'(bus.tw_idx), m_tw[idx]);
        chk("stage",  32'(bus.stage),  m_s[idx]);
      end
      if (waiting && idx == abort_idx) aborted = 1;
      if (exp_bs) begin
        cap_a[idx] = int'(bus.a_addr); cap_b[idx] = int'(bus.b_addr); cap_tw[idx] = int'(bus.tw_idx);
        issue_pending = 0; waiting = 1; wait_left = $urandom_range(0, lat_max);
      end
      if (acc) waiting = 0;
      acc_prev = acc;
      if (exp_wr) begin
        idx++;
        if (idx == NB) done_pending = 1; else issue_pending = 1;
      end else if (exp_done) begin
        done_pending = 0; done_cycle = cyc; finished = 1;
      end
    end
    if (!aborted) begin
      chk("run_completes", 32'(finished), 1);
      chk("bf_start_count", nbs, NB);
      chk("wr_en_count", nwr, NB);
    end
    $display("run lat_max=%0d hold_idx=%0d poke=%0d: cycles=%0d butterflies=%0d aborted=%0d",
             lat_max, hold_idx, poke, cyc, nbs, aborted);
  endtask

  // Idle after a run: stray bf_done ignored, nothing issued, last addresses retained.
  task automatic idle_checks();
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      bus.start = 1'b0; bus.hold = 1'b0; bus.bf_done = (i == 0);
      #1;
      chk("idle_bf_start", 32'(bus.bf_start), 0);
      chk("idle_wr_en",    32'(bus.wr_en),    0);
      chk("idle_done",     32'(bus.done),     0);
      chk("idle_busy",     32'(bus.busy),     0);
      chk("idle_a_keep",   32'(bus.a_addr),   m_a[NB-1]);
      chk("idle_b_keep",   32'(bus.b_addr),   m_b[NB-1]);
      chk("idle_tw_keep",  32'(bus.tw_idx),   m_tw[NB-1]);
      chk("idle_stage_keep", 32'(bus.stage),  m_s[NB-1]);
    end
  endtask

  initial begin
    int  dc;
    bit  ab;
    int  n;
    n = 0;
    for (int s = 0; s < LOG2N; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        int span;
        span    = 1 << s;
        m_s[n]  = s;
        m_a[n]  = (k / span) * 2 * span + (k % span);
        m_b[n]  = m_a[n] + span;
        m_tw[n] = (k % span) * ((N / 2) / span);
        n++;
      end
    end

    nReset = 1'b0; bus.start = 1'b0; bus.hold = 1'b0; bus.bf_done = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk_all_zero("reset");
    nReset = 1'b1;

    // Fixed one-cycle bf_done latency: 37 cycles to done, spot-check the listed addresses.
    run_fft(0, -1, 1'b0, -1, dc, ab);
    chk("done_cycle_fixed", dc, 37);
    chk("s0k0_a", cap_a[0], 0);   chk("s0k0_b", cap_b[0], 1);   chk("s0k0_tw", cap_tw[0], 0);
    chk("s1k1_a", cap_a[5], 1);   chk("s1k1_b", cap_b[5], 3);   chk("s1k1_tw", cap_tw[5], 2);
    chk("s2k3_a", cap_a[11], 3);  chk("s2k3_b", cap_b[11], 7);  chk("s2k3_tw", cap_tw[11], 3);
    chk("s2k2_a", cap_a[10], 2);  chk("s2k2_b", cap_b[10], 6);  chk("s2k2_tw", cap_tw[10], 2);
    idle_checks();

    // Random bf_done latency with stray bf_done pulses outside WAIT.
    run_fft(5, -1, 1'b0, -1, dc, ab);
    idle_checks();

    // Hold for 4 cycles at ISSUE of s1,k2, plus start pokes mid-run and in DONE.
    run_fft(0, 6, 1'b1, -1, dc, ab);
    chk("done_cycle_hold", dc, 41);
    chk("hold_resume_a", cap_a[6], 4);
    chk("hold_resume_b", cap_b[6], 6);
    idle_checks();

    // Reset during WAIT of s1,k0.
    run_fft(0, -1, 1'b0, 4, dc, ab);
    chk("abort_reached", 32'(ab), 1);
    bus.start = 1'b0; bus.hold = 1'b0; bus.bf_done = 1'b0;
    nReset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge Clock);
    #1;
    chk_all_zero("reset_held");
    nReset = 1'b1;

    // Fresh run after reset must start at s0,k0.
    run_fft(3, -1, 1'b0, -1, dc, ab);
    chk("fresh_s0k0_a", cap_a[0], 0);
    chk("fresh_s0k0_b", cap_b[0], 1);
    idle_checks();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
